// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared calc definitions for the binary-to-BCD path:
// digit width, add-3 threshold, FSM states, sizing helper.
package bin_to_bcd_seq_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_THRESH = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Decimal digits needed to show 2^w-1.
  function automatic int digits_for_width(input int w);
    longint v;
    int     d;
    v = (longint'(1) << w) - 1;
    d = 1;
    while (v > 9) begin
      v = v / 10;
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/shift_or_addthree.sv
// Double-dabble correction cell:
// a BCD digit above 4 gets +3 before the shift.
module shift_or_addthree
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);

  always_comb begin
    q = d;
    if (d >= BCD_DIGIT_W'(ADD3_THRESH))
      q = d + BCD_DIGIT_W'(3);
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock,
// with start/ready/done handshake toward the arithmetic core.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = digits_for_width(BIN_W)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  state_t           state;
  state_t           nxt;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    cor;
  logic [BIN_W-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             sticky;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    shift_or_addthree u_add3 (
      .d (acc[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q (cor[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      sh       <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= nxt;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            sh     <= bin_in;
            cnt    <= CW'(BIN_W);
            sticky <= 1'b0;
          end
        end
        SHIFT: begin
          // The MSB leaving the accumulator is lost precision.
          {acc, sh} <= {cor[BW-2:0], sh, 1'b0};
          sticky    <= sticky | cor[BW-1];
          cnt       <= cnt - CW'(1);
        end
        DONE: begin
          bcd_out  <= acc;
          overflow <= sticky;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: vector table, busy/reset
// corner sequences and a two-digit overflow instance.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [7:0]  bin_in = '0;
  logic [7:0]  bin2 = '0;
  logic        ready, busy, done, overflow;
  logic [11:0] bcd_out;
  logic        ready2, busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ndone = 0;
  int ndone2 = 0;
  int dcyc = 0;
  int dcyc2 = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  exp_t q[$];
  exp_t q2[$];
  vec_t tbl[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .start    (start2),
    .bin_in   (bin2),
    .ready    (ready2),
    .busy     (busy2),
    .done     (done2),
    .bcd_out  (bcd2),
    .overflow (ovf2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got none/extra want expected event", nm);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      ndone++;
      dcyc = cyc;
      if (q.size() == 0) miss("spurious_done");
      else begin
        e = q.pop_front();
        chk("bcd", 32'(bcd_out), 32'(e.bcd));
        chk("ovf", 32'(overflow), 32'(e.ovf));
      end
    end
    if (done2) begin
      ndone2++;
      dcyc2 = cyc;
      if (q2.size() == 0) miss("spurious_done2");
      else begin
        e = q2.pop_front();
        chk("bcd2", 32'(bcd2), 32'(e.bcd));
        chk("ovf2", 32'(ovf2), 32'(e.ovf));
      end
    end
  end

  task automatic conv(input bit sel, input logic [7:0] v,
                      input logic [11:0] eb, input logic eo);
    int n0;
    int t0;
    bit ok;
    bit got;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #2;
      if ((sel ? ready2 : ready) == 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) miss("ready_wait");
    n0 = sel ? ndone2 : ndone;
    if (sel) begin
      q2.push_back(exp_t'{eb, eo});
      start2 = 1'b1;
      bin2   = v;
    end else begin
      q.push_back(exp_t'{eb, eo});
      start  = 1'b1;
      bin_in = v;
    end
    @(posedge clk);
    #1;
    t0     = cyc;
    start  = 1'b0;
    start2 = 1'b0;
    bin_in = 8'($urandom);
    bin2   = 8'($urandom);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if ((sel ? ndone2 : ndone) > n0) begin
        got = 1;
        break;
      end
    end
    if (!got) miss("done_timeout");
    else begin
      chk("latency", (sel ? dcyc2 : dcyc) - t0, 9);
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(sel ? done2 : done), 0);
      chk("ready_back", 32'(sel ? ready2 : ready), 1);
    end
  endtask

  initial begin : wd
    #500000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n0;
    tbl[0] = vec_t'{8'd255, 12'h255, 1'b0};
    tbl[1] = vec_t'{8'd0,   12'h000, 1'b0};
    tbl[2] = vec_t'{8'd9,   12'h009, 1'b0};
    tbl[3] = vec_t'{8'd10,  12'h010, 1'b0};
    tbl[4] = vec_t'{8'd99,  12'h099, 1'b0};
    tbl[5] = vec_t'{8'd100, 12'h100, 1'b0};
    tbl[6] = vec_t'{8'd199, 12'h199, 1'b0};
    tbl[7] = vec_t'{8'd128, 12'h128, 1'b0};
    tbl[8] = vec_t'{8'd1,   12'h001, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_bcd", 32'(bcd_out), 0);
      chk("rst_ovf", 32'(overflow), 0);
    end

    for (int k = 0; k < 9; k++)
      conv(1'b0, tbl[k].bin, tbl[k].bcd, tbl[k].ovf);

    // Starts during SHIFT and during DONE must be dropped.
    @(negedge clk);
    #2;
    n0 = ndone;
    q.push_back(exp_t'{12'h047, 1'b0});
    start  = 1'b1;
    bin_in = 8'd47;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 10; k++) begin
      start  = (k == 3 || k == 9);
      bin_in = start ? 8'd200 : 8'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("busy_one_done", ndone - n0, 1);
    chk("busy_bcd_hold", 32'(bcd_out), 32'h047);

    // Reset mid-conversion aborts without a done.
    @(negedge clk);
    #2;
    n0 = ndone;
    start  = 1'b1;
    bin_in = 8'd123;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bcd", 32'(bcd_out), 0);
    chk("abort_ovf", 32'(overflow), 0);
    repeat (15) @(negedge clk);
    #2;
    chk("abort_no_done", ndone - n0, 0);
    conv(1'b0, 8'd88, 12'h088, 1'b0);

    conv(1'b1, 8'd100, 12'h000, 1'b1);
    conv(1'b1, 8'd99,  12'h099, 1'b0);
    conv(1'b1, 8'd255, 12'h055, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Instantiates the team's existing 4-bit add-3 correction cell (shift_or_addthree) once per BCD digit, so the correction logic is not duplicated.
- Feeds BCD digits to the calculator's display/digit-mux stage.
- Simple start/ready/done handshake toward the arithmetic core.

Parameters:
- BIN_W, 8, width of the unsigned binary input.
- DIGITS, 3, number of BCD output digits; the default covers 0..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only when ready=1.
- bin_in  input  BIN_W  unsigned value; captured in the cycle start is accepted.
- ready  output  1  high in IDLE only.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse when bcd_out/overflow update.
- bcd_out  output  4*DIGITS  packed BCD result, digit 0 in [3:0]; held between conversions.
- overflow  output  1  result did not fit in DIGITS digits; updates with done.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - ready=1, busy=0, done=0, bcd_out=0, overflow=0.
  - The internal shift register, counter and sticky overflow flag are cleared.
  - Reset mid-conversion aborts the conversion with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 loads the shift register {bcd_acc=0, bin_sh=bin_in}, sets cnt=BIN_W, clears sticky_ovf, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, each cycle:
  - Each 4-bit digit of bcd_acc passes through an add-3 cell: digit>4 becomes digit+3, otherwise unchanged (4-bit result).
  - Then {corrected bcd_acc, bin_sh} shifts left by 1.
  - The bit shifted out of the top of bcd_acc is ORed into sticky_ovf.
  - cnt decrements; when cnt reaches 1 in this cycle, the next state is DONE.
- DONE, exactly one cycle:
  - bcd_out <= bcd_acc, overflow <= sticky_ovf, done=1.
  - Next state is IDLE.
- Latency:
  - start accepted on edge N.
  - BIN_W SHIFT cycles follow.
  - done=1 and new bcd_out are visible in the cycle after edge N+BIN_W+1 (cycle 10 for BIN_W=8).
  - Throughput is one conversion per BIN_W+2 cycles.
- Handshake rules:
  - start while busy is ignored; it is not queued.
  - bin_in is don't-care except in the accept cycle.
  - start in the DONE cycle is ignored because ready=0 there.
- Arithmetic:
  - All add-3 sums are 4-bit; digits never exceed 9 after correction when no overflow occurs.
  - Counter width is clog2(BIN_W+1).
- Boundary conditions:
  - bin_in=0 gives bcd_out=0.
  - bin_in=2^BIN_W-1 with the default DIGITS must not overflow.
  - If overflow=1, bcd_out holds the truncated low digits; it is not saturated.
- Output timing: outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared calc package:
  - BCD_DIGIT_W=4.
  - ADD3_THRESH=5.
  - State enum {IDLE, SHIFT, DONE}.
  - A function digits_for_width(BIN_W) used to pick defaults.
- Sub-module: the existing add-3 correction cell, instantiated DIGITS times in a generate loop.
- FSM, counter and shift register stay in bin_to_bcd_seq.

Test Plan:
- After reset, hold start=0 for 5 cycles -> ready=1, busy=0, done=0, bcd_out=12'h000, overflow=0 throughout.
- bin_in=8'd255, start pulsed -> done pulses exactly 10 cycles later; bcd_out=12'h255, overflow=0; ready returns the next cycle.
- Sweep bin_in=0, 9, 10, 99, 100, 199 -> bcd_out=000, 009, 010, 099, 100, 199, each with one done pulse.
- Start bin_in=8'd47; pulse start again with bin_in=8'd200 at cycles 3 and 9 (busy) -> exactly one done; bcd_out=12'h047.
- Start bin_in=8'd123; assert rst at cycle 5 for 1 cycle -> no done, all outputs 0; a new start with 8'd88 gives bcd_out=12'h088.
- Run with DIGITS=2 and bin_in=8'd100 -> overflow=1, bcd_out=8'h00; then bin_in=8'd99 -> overflow=0, bcd_out=8'h99.
